spi_serf: RTL and testbench

Synthesizable SPI serf (responder) that sits on the far end of the link driven by the team's 16-bit SPI monarch, giving on-chip blocks a real SPI target instead of a behavioral model. It oversamples SS_n, SCLK and MOSI in the system clock domain. It decodes 16-bit MSB-first frames and reports the command byte mid-frame so a register file can supply read data. It shifts a response word out on MISO in the same frame.

---
 rtl/spi_serf_if.sv | 26 ++
 rtl/spi_serf.sv | 179 +++++++++++++++++
 tb/tb_spi_serf.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/spi_serf_if.sv
// Pin and register-file bundle between the SPI serf and its surroundings.
// The slave view is the serf itself; the master view is the monarch plus register-file side.
interface spi_serf_if;
    logic        SS_n;
    logic        SCLK;
    logic        MOSI;
    logic        MISO;
    logic [15:0] tx_data;
    logic [7:0]  rsp_data;
    logic        cmd_vld;
    logic [7:0]  cmd;
    logic        rx_rdy;
    logic [15:0] rx_data;
    logic        frm_err;
    logic        busy;

    modport slave (
        input  SS_n, SCLK, MOSI, tx_data, rsp_data,
        output MISO, cmd_vld, cmd, rx_rdy, rx_data, frm_err, busy
    );

    modport master (
        output SS_n, SCLK, MOSI, tx_data, rsp_data,
        input  MISO, cmd_vld, cmd, rx_rdy, rx_data, frm_err, busy
    );
endinterface

// File: rtl/spi_serf.sv
// SPI responder: oversamples SS_n/SCLK/MOSI in clk, decodes 16-bit MSB-first frames,
// reports the command byte mid-frame and returns a response word on MISO.
module spi_serf #(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst,
    spi_serf_if.slave  bus
);

    typedef enum logic [1:0] {ARM, IDLE, SHIFT} state_t;

    localparam logic [1:0] ARM_WAIT = 2'(SYNC_STAGES);

    state_t state, state_d;

    logic [SYNC_STAGES-1:0] ss_sync_p0, sclk_sync_p0, mosi_sync_p0;
    logic ss_prev_p1, sclk_prev_p1;
    logic ss_s, sclk_s, mosi_s;
    logic ss_rise, ss_fall, sclk_rise, sclk_fall;

    logic [1:0]  arm_cnt;
    logic        arm_done;

    logic [15:0] shft;
    logic        mosi_smpl;
    logic [4:0]  bit_cnt;
    logic [7:0]  rsp_q;
    logic        miso_q;
    logic        cmd_vld_q;
    logic [7:0]  cmd_q;
    logic        rx_rdy_q;
    logic [15:0] rx_data_q;
    logic        frm_err_q;

    logic start_frm, do_rise, do_fall, end_ok, end_err;

    function automatic logic [4:0] sat_inc(input logic [4:0] v);
        return (v == 5'd17) ? 5'd17 : v + 5'd1;
    endfunction

    // ---- stage p0/p1: synchronizers and edge history ----
    always_ff @(posedge clk) begin
        if (rst) begin
            ss_sync_p0   <= '1;
            sclk_sync_p0 <= '1;
            mosi_sync_p0 <= '0;
            ss_prev_p1   <= 1'b1;
            sclk_prev_p1 <= 1'b1;
        end else begin
            ss_sync_p0   <= {ss_sync_p0[SYNC_STAGES-2:0], bus.SS_n};
            sclk_sync_p0 <= {sclk_sync_p0[SYNC_STAGES-2:0], bus.SCLK};
            mosi_sync_p0 <= {mosi_sync_p0[SYNC_STAGES-2:0], bus.MOSI};
            ss_prev_p1   <= ss_s;
            sclk_prev_p1 <= sclk_s;
        end
    end

    assign ss_s      = ss_sync_p0[SYNC_STAGES-1];
    assign sclk_s    = sclk_sync_p0[SYNC_STAGES-1];
    assign mosi_s    = mosi_sync_p0[SYNC_STAGES-1];
    assign ss_rise   = ss_s & ~ss_prev_p1;
    assign ss_fall   = ~ss_s & ss_prev_p1;
    assign sclk_rise = sclk_s & ~sclk_prev_p1;
    assign sclk_fall = ~sclk_s & sclk_prev_p1;

    // The synchronizer reset value reads as "SS_n high"; wait until the chain has
    // refilled from the pin so a frame already in progress at reset is not joined mid-way.
    assign arm_done = (arm_cnt == ARM_WAIT);

    always_ff @(posedge clk) begin
        if (rst)
            arm_cnt <= 2'd0;
        else if (state == ARM && !arm_done)
            arm_cnt <= arm_cnt + 2'd1;
    end

    always_ff @(posedge clk) begin
        if (rst)
            state <= ARM;
        else
            state <= state_d;
    end

    always_comb begin
        state_d   = state;
        start_frm = 1'b0;
        do_rise   = 1'b0;
        do_fall   = 1'b0;
        end_ok    = 1'b0;
        end_err   = 1'b0;
        case (state)
            ARM: begin
                if (arm_done && ss_s)
                    state_d = IDLE;
            end
            IDLE: begin
                if (ss_fall) begin
                    state_d   = SHIFT;
                    start_frm = 1'b1;
                end
            end
            SHIFT: begin
                // An SS_n rise wins over any SCLK edge seen in the same clk.
                if (ss_rise) begin
                    state_d = IDLE;
                    end_ok  = (bit_cnt == 5'd16);
                    end_err = (bit_cnt != 5'd16);
                end else begin
                    do_rise = sclk_rise;
                    do_fall = sclk_fall && (bit_cnt >= 5'd1) && (bit_cnt <= 5'd15);
                end
            end
            default: state_d = ARM;
        endcase
    end

    // ---- stage p2: shift register, counters and output registers ----
    always_ff @(posedge clk) begin
        if (rst) begin
            shft      <= 16'h0000;
            mosi_smpl <= 1'b0;
            bit_cnt   <= 5'd0;
            rsp_q     <= 8'h00;
            miso_q    <= 1'b0;
            cmd_vld_q <= 1'b0;
            cmd_q     <= 8'h00;
            rx_rdy_q  <= 1'b0;
            rx_data_q <= 16'h0000;
            frm_err_q <= 1'b0;
        end else begin
            cmd_vld_q <= 1'b0;
            rx_rdy_q  <= 1'b0;
            frm_err_q <= 1'b0;
            miso_q    <= ~ss_s & shft[15];

            if (start_frm) begin
                shft    <= bus.tx_data;
                bit_cnt <= 5'd0;
            end

            if (do_rise) begin
                mosi_smpl <= mosi_s;
                bit_cnt   <= sat_inc(bit_cnt);
                if (bit_cnt == 5'd7) begin
                    cmd_vld_q <= 1'b1;
                    cmd_q     <= {shft[6:0], mosi_s};
                end
            end

            // The upper byte is replaced by the response byte at the mid-frame fall.
            if (do_fall) begin
                if (bit_cnt == 5'd8)
                    shft <= {rsp_q, shft[6:0], mosi_smpl};
                else
                    shft <= {shft[14:0], mosi_smpl};
            end

            if (cmd_vld_q)
                rsp_q <= cmd_q[7] ? bus.rsp_data : shft[14:7];

            if (end_ok) begin
                rx_data_q <= {shft[14:0], mosi_smpl};
                rx_rdy_q  <= 1'b1;
            end
            if (end_err)
                frm_err_q <= 1'b1;
        end
    end

    assign bus.MISO    = miso_q;
    assign bus.cmd_vld = cmd_vld_q;
    assign bus.cmd     = cmd_q;
    assign bus.rx_rdy  = rx_rdy_q;
    assign bus.rx_data = rx_data_q;
    assign bus.frm_err = frm_err_q;
    assign bus.busy    = (state == SHIFT);

endmodule

// File: tb/tb_spi_serf.sv
// Directed bench for spi_serf: a monarch model drives frames at clk/32 and
// compares command, MISO word, received frame and pulse counts against hand-computed values.
module tb_spi_serf;

    localparam int S    = 2;
    localparam int HALF = 16;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    spi_serf_if bus();

    spi_serf #(.SYNC_STAGES(S)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;
    int n_cmd = 0, n_rx = 0, n_err = 0;
    logic [7:0] rsp_val = 8'h00;

    // rsp_data is only meaningful in the clk right after cmd_vld; garbage otherwise.
    always @(negedge clk) begin
        if (bus.cmd_vld === 1'b1) n_cmd++;
        if (bus.rx_rdy  === 1'b1) n_rx++;
        if (bus.frm_err === 1'b1) n_err++;
        bus.rsp_data = (bus.cmd_vld === 1'b1) ? rsp_val : ~rsp_val;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic frame(input logic [15:0] w, input int nbits, input int gap,
                         output logic [15:0] got);
        got = 16'h0000;
        bus.SS_n = 1'b0;
        clks(HALF);
        for (int i = 0; i < nbits; i++) begin
            bus.SCLK = 1'b0;
            bus.MOSI = w[15 - (i % 16)];
            clks(HALF);
            bus.SCLK = 1'b1;
            if (i < 16) got = {got[14:0], bus.MISO};
            clks(HALF);
        end
        bus.SS_n = 1'b1;
        clks(gap);
    endtask

    typedef struct {
        logic [15:0] mosi;
        logic [15:0] tx;
        logic [7:0]  rsp;
        logic [7:0]  exp_cmd;
        logic [15:0] exp_miso;
    } vec_t;

    vec_t vecs[4];

    initial begin
        logic [15:0] got, got2;
        int c0, r0, e0;

        vecs[0] = '{16'h8F00, 16'h0000, 8'h6A, 8'h8F, 16'h006A};
        vecs[1] = '{16'h0D02, 16'hA5C3, 8'h77, 8'h0D, 16'hA5C3};
        vecs[2] = '{16'hC001, 16'h5A00, 8'h3C, 8'hC0, 16'h5A3C};
        vecs[3] = '{16'h7FFF, 16'h3C96, 8'hFF, 8'h7F, 16'h3C96};

        rst = 1'b1;
        bus.SS_n = 1'b1;
        bus.SCLK = 1'b1;
        bus.MOSI = 1'b0;
        bus.tx_data = 16'h0000;
        clks(4);
        rst = 1'b0;
        clks(1);
        check("reset_miso",    {31'd0, bus.MISO},    32'd0);
        check("reset_cmd_vld", {31'd0, bus.cmd_vld}, 32'd0);
        check("reset_cmd",     {24'd0, bus.cmd},     32'd0);
        check("reset_rx_rdy",  {31'd0, bus.rx_rdy},  32'd0);
        check("reset_rx_data", {16'd0, bus.rx_data}, 32'd0);
        check("reset_frm_err", {31'd0, bus.frm_err}, 32'd0);
        check("reset_busy",    {31'd0, bus.busy},    32'd0);
        clks(10);

        for (int v = 0; v < 4; v++) begin
            bus.tx_data = vecs[v].tx;
            rsp_val = vecs[v].rsp;
            c0 = n_cmd; r0 = n_rx; e0 = n_err;
            frame(vecs[v].mosi, 16, 10, got);
            check("vec_cmd_cnt",  n_cmd - c0, 32'd1);
            check("vec_cmd",      {24'd0, bus.cmd}, {24'd0, vecs[v].exp_cmd});
            check("vec_miso",     {16'd0, got}, {16'd0, vecs[v].exp_miso});
            check("vec_rx_cnt",   n_rx - r0, 32'd1);
            check("vec_rx_data",  {16'd0, bus.rx_data}, {16'd0, vecs[v].mosi});
            check("vec_err_cnt",  n_err - e0, 32'd0);
            check("vec_busy",     {31'd0, bus.busy}, 32'd0);
        end

        // Abort after 10 bits, then a clean frame.
        bus.tx_data = 16'h0000;
        rsp_val = 8'h11;
        r0 = n_rx; e0 = n_err;
        frame(16'hBEEF, 10, 10, got);
        check("abort_err_cnt", n_err - e0, 32'd1);
        check("abort_rx_cnt",  n_rx - r0, 32'd0);
        check("abort_rx_data", {16'd0, bus.rx_data}, 32'h7FFF);
        check("abort_busy",    {31'd0, bus.busy}, 32'd0);
        r0 = n_rx; e0 = n_err;
        frame(16'h1234, 16, 10, got);
        check("after_abort_rx_cnt",  n_rx - r0, 32'd1);
        check("after_abort_rx_data", {16'd0, bus.rx_data}, 32'h1234);
        check("after_abort_err_cnt", n_err - e0, 32'd0);

        // Overrun: 17 clocks in one frame.
        r0 = n_rx; e0 = n_err;
        frame(16'h4321, 17, 10, got);
        check("overrun_err_cnt", n_err - e0, 32'd1);
        check("overrun_rx_cnt",  n_rx - r0, 32'd0);
        check("overrun_rx_data", {16'd0, bus.rx_data}, 32'h1234);

        // Reset pulsed after 5 bits while SS_n stays low.
        bus.tx_data = 16'hFFFF;
        c0 = n_cmd; r0 = n_rx; e0 = n_err;
        bus.SS_n = 1'b0;
        clks(HALF);
        for (int i = 0; i < 16; i++) begin
            bus.SCLK = 1'b0;
            bus.MOSI = i[0];
            clks(HALF);
            bus.SCLK = 1'b1;
            clks(HALF);
            if (i == 4) begin
                rst = 1'b1;
                clks(1);
                rst = 1'b0;
                clks(2);
                check("midrst_miso",    {31'd0, bus.MISO},    32'd0);
                check("midrst_cmd",     {24'd0, bus.cmd},     32'd0);
                check("midrst_rx_data", {16'd0, bus.rx_data}, 32'd0);
                check("midrst_busy",    {31'd0, bus.busy},    32'd0);
            end
        end
        bus.SS_n = 1'b1;
        clks(10);
        check("midrst_cmd_cnt", n_cmd - c0, 32'd0);
        check("midrst_rx_cnt",  n_rx - r0, 32'd0);
        check("midrst_err_cnt", n_err - e0, 32'd0);

        bus.tx_data = 16'h0000;
        rsp_val = 8'h5B;
        r0 = n_rx;
        frame(16'hA600, 16, 10, got);
        check("postrst_cmd",     {24'd0, bus.cmd}, 32'h00A6);
        check("postrst_miso",    {16'd0, got}, 32'h005B);
        check("postrst_rx_cnt",  n_rx - r0, 32'd1);
        check("postrst_rx_data", {16'd0, bus.rx_data}, 32'hA600);

        // Back-to-back frames with minimum SS_n-high gap.
        r0 = n_rx; e0 = n_err;
        rsp_val = 8'h8D;
        frame(16'hA611, 16, S + 2, got);
        rsp_val = 8'h99;
        frame(16'hA722, 16, 10, got2);
        check("b2b_miso0",   {16'd0, got},  32'h008D);
        check("b2b_miso1",   {16'd0, got2}, 32'h0099);
        check("b2b_rx_cnt",  n_rx - r0, 32'd2);
        check("b2b_err_cnt", n_err - e0, 32'd0);
        check("b2b_rx_data", {16'd0, bus.rx_data}, 32'hA722);
        check("b2b_cmd",     {24'd0, bus.cmd}, 32'h00A7);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
